branch_fwd_ctrl: RTL and testbench

- Control end of the ID-stage branch forwarding path. Generates the 2-bit select codes for the two branch-comparator forwarding muxes: 00 = register-file value, 01 = MEM/WB value, 10 = EX/MEM value, 11 = reserved (mux outputs 0).
- Keeps a shadow copy of the destination-register state of the EX, MEM and WB stages. Stalls ID when a branch operand cannot yet be forwarded.
- Sits beside the hazard unit in the 5-stage pipeline. Its stall output is ORed into the PC/IF-ID write-enable and the ID/EX bubble control.

---
 rtl/branch_fwd_ctrl.sv | 109 ++++++++++
 tb/tb_branch_fwd_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/branch_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_fwd_ctrl
// Function : ID-stage branch-comparator forwarding control. Tracks a shadow
//            copy of the EX/MEM/WB destination state, picks the forwarding
//            source for each comparator operand and stalls ID when a branch
//            operand cannot be forwarded yet. Counts stalled cycles.
// Revision : 1.0 - initial release
// ============================================================================
module branch_fwd_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_is_branch,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_dest,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  output logic [1:0]       sel_a,
  output logic [1:0]       sel_b,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  // Mux select encodings (11 is reserved and never produced)
  localparam logic [1:0] C_SEL_RF  = 2'b00;
  localparam logic [1:0] C_SEL_WB  = 2'b01;
  localparam logic [1:0] C_SEL_MEM = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       reg_write;
    logic       mem_read;
  } shadow_t;

  shadow_t          ex_q, mem_q, wb_q;
  shadow_t          ex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [2:0]       res_a, res_b;
  logic             stall_raw;

  // A shadow entry only matters if it really writes a non-zero register
  function automatic logic is_writer(input shadow_t e);
    return e.valid & e.reg_write & (e.dest != 5'd0);
  endfunction

  // Returns {stall, sel}; nearest stage wins
  function automatic logic [2:0] resolve(input logic       active,
                                         input logic [4:0] r,
                                         input shadow_t    ex,
                                         input shadow_t    mem,
                                         input shadow_t    wb);
    logic [2:0] res;
    res = {1'b0, C_SEL_RF};
    if (active && (r != 5'd0)) begin
      if (is_writer(ex) && (ex.dest == r)) begin
        res = {1'b1, C_SEL_RF};              // result not computed yet
      end else if (is_writer(mem) && (mem.dest == r)) begin
        if (mem.mem_read) res = {1'b1, C_SEL_RF}; // load data arrives end of MEM
        else              res = {1'b0, C_SEL_MEM};
      end else if (is_writer(wb) && (wb.dest == r)) begin
        res = {1'b0, C_SEL_WB};
      end
    end
    return res;
  endfunction

  // Operand resolution, stall merge and reset masking of the outputs
  always_comb begin
    res_a     = resolve(id_valid & id_is_branch, id_rs, ex_q, mem_q, wb_q);
    res_b     = resolve(id_valid & id_is_branch, id_rt, ex_q, mem_q, wb_q);
    stall_raw = res_a[2] | res_b[2];
    stall     = rst_n & stall_raw;
    sel_a     = (rst_n && !stall_raw) ? res_a[1:0] : C_SEL_RF;
    sel_b     = (rst_n && !stall_raw) ? res_b[1:0] : C_SEL_RF;
  end

  // Next EX entry (bubble on stall) and saturating stall counter
  always_comb begin
    ex_d = '{valid: id_valid, dest: id_dest,
             reg_write: id_reg_write, mem_read: id_mem_read};
    if (stall) ex_d = '0;
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Shadow pipeline advance and counter update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_fwd_ctrl
// Function : Directed vector bench for branch_fwd_ctrl, plus counter
//            saturation (narrow instance) and reset-during-stall sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_fwd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_is_branch, id_reg_write, id_mem_read;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic [1:0]  sel_a, sel_b, s_sel_a, s_sel_b;
  logic        stall, s_stall;
  logic [15:0] stall_cnt;
  logic [1:0]  s_cnt;

  int total = 0;
  int bad   = 0;

  branch_fwd_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_is_branch(id_is_branch),
    .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .sel_a(sel_a), .sel_b(sel_b), .stall(stall),
    .stall_cnt(stall_cnt)
  );

  // Narrow counter instance, same stimulus, for saturation checking
  branch_fwd_ctrl #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_is_branch(id_is_branch),
    .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .sel_a(s_sel_a), .sel_b(s_sel_b), .stall(s_stall),
    .stall_cnt(s_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, br;
    logic [4:0]  rs, rt, dest;
    logic        rw, mr;
    logic [1:0]  ea, eb;
    logic        es;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic br, logic [4:0] rs, logic [4:0] rt,
                              logic [4:0] dest, logic rw, logic mr, logic [1:0] ea,
                              logic [1:0] eb, logic es, logic [15:0] ec);
    vec_t x;
    x.v = v; x.br = br; x.rs = rs; x.rt = rt; x.dest = dest; x.rw = rw; x.mr = mr;
    x.ea = ea; x.eb = eb; x.es = es; x.ec = ec;
    return x;
  endfunction

  // Shorthands: ALU producer, load producer, branch, bubble
  function automatic vec_t alu(logic [4:0] d, logic [15:0] ec);
    return mk(1, 0, 5'd1, 5'd2, d, 1, 0, 2'b00, 2'b00, 0, ec);
  endfunction
  function automatic vec_t ld(logic [4:0] d, logic [15:0] ec);
    return mk(1, 0, 5'd3, 5'd0, d, 1, 1, 2'b00, 2'b00, 0, ec);
  endfunction
  function automatic vec_t br(logic [4:0] rs, logic [4:0] rt, logic [1:0] ea,
                              logic [1:0] eb, logic es, logic [15:0] ec);
    return mk(1, 1, rs, rt, 5'd0, 0, 0, ea, eb, es, ec);
  endfunction
  function automatic vec_t nop(logic [15:0] ec);
    return mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'b00, 2'b00, 0, ec);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t x);
    id_valid = x.v; id_is_branch = x.br; id_rs = x.rs; id_rt = x.rt;
    id_dest = x.dest; id_reg_write = x.rw; id_mem_read = x.mr;
  endtask

  task automatic nops3(logic [15:0] ec);
    for (int k = 0; k < 3; k++) tbl.push_back(nop(ec));
  endtask

  // Apply one vector after the edge and check mid-cycle
  task automatic apply_chk(vec_t x, string tag);
    @(posedge clk); #1;
    drive(x);
    @(negedge clk);
    chk({tag, " sel_a"}, 32'(sel_a), 32'(x.ea));
    chk({tag, " sel_b"}, 32'(sel_b), 32'(x.eb));
    chk({tag, " stall"}, 32'(stall), 32'(x.es));
    chk({tag, " cnt"},   32'(stall_cnt), 32'(x.ec));
  endtask

  initial begin
    // ALU producer right before branch: 1 stall, then MEM forward
    tbl.push_back(alu(5'd8, 0));
    tbl.push_back(br(5'd8, 5'd9, 2'b00, 2'b00, 1, 0));
    tbl.push_back(br(5'd8, 5'd9, 2'b10, 2'b00, 0, 1));
    nops3(1);
    // Load right before branch: 2 stalls, then WB forward on operand B
    tbl.push_back(ld(5'd8, 1));
    tbl.push_back(br(5'd9, 5'd8, 2'b00, 2'b00, 1, 1));
    tbl.push_back(br(5'd9, 5'd8, 2'b00, 2'b00, 1, 2));
    tbl.push_back(br(5'd9, 5'd8, 2'b00, 2'b01, 0, 3));
    nops3(3);
    // add $8; add $9; beq $9,$8: stall on $9 in EX, then $9 in MEM, $8 in WB
    tbl.push_back(alu(5'd8, 3));
    tbl.push_back(alu(5'd9, 3));
    tbl.push_back(br(5'd9, 5'd8, 2'b00, 2'b00, 1, 3));
    tbl.push_back(br(5'd9, 5'd8, 2'b10, 2'b01, 0, 4));
    nops3(4);
    // add $8; nop; beq $8,$0: MEM forward, no stall
    tbl.push_back(alu(5'd8, 4));
    tbl.push_back(nop(4));
    tbl.push_back(br(5'd8, 5'd0, 2'b10, 2'b00, 0, 4));
    nops3(4);
    // Writes to $0 are never forwarded
    tbl.push_back(alu(5'd0, 4));
    tbl.push_back(br(5'd0, 5'd0, 2'b00, 2'b00, 0, 4));
    nops3(4);
    // add $8; sub $8; beq $8,$8: EX match stalls, then nearest (MEM) wins
    tbl.push_back(alu(5'd8, 4));
    tbl.push_back(alu(5'd8, 4));
    tbl.push_back(br(5'd8, 5'd8, 2'b00, 2'b00, 1, 4));
    tbl.push_back(br(5'd8, 5'd8, 2'b10, 2'b10, 0, 5));
    nops3(5);
    // Non-branch consumer and a branch-flagged bubble never stall
    tbl.push_back(alu(5'd8, 5));
    tbl.push_back(mk(1, 0, 5'd8, 5'd8, 5'd10, 1, 0, 2'b00, 2'b00, 0, 5));
    tbl.push_back(mk(0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 2'b00, 2'b00, 0, 5));
    nops3(5);
    // Load two ahead of branch: 1 stall, then WB forward
    tbl.push_back(ld(5'd8, 5));
    tbl.push_back(nop(5));
    tbl.push_back(br(5'd8, 5'd0, 2'b00, 2'b00, 1, 5));
    tbl.push_back(br(5'd8, 5'd0, 2'b01, 2'b00, 0, 6));
    nops3(6);

    // Reset state
    drive(nop(0));
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst sel_a", 32'(sel_a), 32'd0);
    chk("rst cnt",   32'(stall_cnt), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply_chk(tbl[i], $sformatf("v%0d", i));

    // Saturation: fresh reset, two load-use pairs = 4 stall edges
    @(posedge clk); #1; drive(nop(0)); rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    for (int p = 0; p < 2; p++) begin
      apply_chk(ld(5'd8, 16'(p * 2)), $sformatf("sat%0d ld", p));
      apply_chk(br(5'd9, 5'd8, 2'b00, 2'b00, 1, 16'(p * 2)), $sformatf("sat%0d s1", p));
      apply_chk(br(5'd9, 5'd8, 2'b00, 2'b00, 1, 16'(p * 2 + 1)), $sformatf("sat%0d s2", p));
      apply_chk(br(5'd9, 5'd8, 2'b00, 2'b01, 0, 16'(p * 2 + 2)), $sformatf("sat%0d go", p));
    end
    chk("sat narrow cnt", 32'(s_cnt), 32'd3);
    apply_chk(nop(4), "sat hold");
    chk("sat narrow hold", 32'(s_cnt), 32'd3);

    // Reset during a stall: stall drops at once, nothing survives
    apply_chk(ld(5'd8, 4), "rs ld");
    apply_chk(br(5'd9, 5'd8, 2'b00, 2'b00, 1, 4), "rs stall");
    rst_n = 1'b0; #1;
    chk("rs stall drop", 32'(stall), 32'd0);
    chk("rs sel_b",      32'(sel_b), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rs post stall", 32'(stall), 32'd0);
    chk("rs post sel_a", 32'(sel_a), 32'd0);
    chk("rs post sel_b", 32'(sel_b), 32'd0);
    chk("rs post cnt",   32'(stall_cnt), 32'd0);
    chk("rs post ncnt",  32'(s_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
